// File: rtl/coin_pkg.sv
// coin_pkg: shared constants for the coin input conditioner.
//   COIN_LO_VAL / COIN_HI_VAL : face values of the two coin channels
//   DB_CYCLES_DEFAULT         : default debounce length (10 ms at 50 MHz)
//   TOTAL_W                   : width of the optional running total
package coin_pkg;

    localparam int COIN_LO_VAL       = 5;
    localparam int COIN_HI_VAL       = 10;
    localparam int DB_CYCLES_DEFAULT = 500000;
    localparam int TOTAL_W           = 12;

endpackage

// File: rtl/coin_debouncer.sv
// coin_debouncer: 2-FF synchroniser, stable-sample debounce and press detect
// for one raw coin switch.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   btn   - raw asynchronous switch input
//   press - high for the cycle whose closing edge flips the debounced level 0 -> 1
module coin_debouncer
    import coin_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic             s1;
    logic             s2;
    logic             lvl;
    logic [CNT_W-1:0] cnt;
    logic             at_tc;

    assign at_tc = (cnt == CNT_W'(DB_CYCLES - 1));

    // Combinational so the top can set its pending flag on the same edge the
    // debounced level flips.
    assign press = s2 && !lvl && at_tc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            lvl <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            if (s2 == lvl) begin
                cnt <= '0;
            end else if (at_tc) begin
                lvl <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner: debounces the two coin switches and issues at most
// one single-cycle coin pulse per cycle, holding coins while the FSM dispenses.
// Optional feature macro: COIN_TOTAL_EN (adds total_cents running total).
// Ports:
//   clk, rst        - system clock, asynchronous active-high reset
//   btn_5, btn_10   - raw coin switches
//   hold            - FSM dispensing; suppresses issue, pending coins kept
//   in_5, in_10     - registered single-cycle coin pulses
//   coin_drop       - registered pulse: a press arrived while its flag was full
//   total_cents     - (COIN_TOTAL_EN only) saturating sum of issued coins
module coin_input_conditioner
    import coin_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_5,
    input  logic               btn_10,
    input  logic               hold,
    output logic               in_5,
    output logic               in_10,
    output logic               coin_drop
`ifdef COIN_TOTAL_EN
    ,
    output logic [TOTAL_W-1:0] total_cents
`endif
);

    logic press_5;
    logic press_10;
    logic pend_5;
    logic pend_10;
    logic issue_5;
    logic issue_10;
    logic drop_5;
    logic drop_10;

    coin_debouncer #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_5 (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_5),
        .press (press_5)
    );

    coin_debouncer #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_10 (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_10),
        .press (press_10)
    );

    // Fixed priority: 5-unit first, 10-unit only when no 5-unit is waiting.
    assign issue_5  = !hold && pend_5;
    assign issue_10 = !hold && !pend_5 && pend_10;

    // A flag being issued this cycle has room for a new press.
    assign drop_5  = press_5  && pend_5  && !issue_5;
    assign drop_10 = press_10 && pend_10 && !issue_10;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_5    <= 1'b0;
            pend_10   <= 1'b0;
            in_5      <= 1'b0;
            in_10     <= 1'b0;
            coin_drop <= 1'b0;
        end else begin
            in_5      <= issue_5;
            in_10     <= issue_10;
            coin_drop <= drop_5 || drop_10;
            if (press_5)
                pend_5 <= 1'b1;
            else if (issue_5)
                pend_5 <= 1'b0;
            if (press_10)
                pend_10 <= 1'b1;
            else if (issue_10)
                pend_10 <= 1'b0;
        end
    end

`ifdef COIN_TOTAL_EN
    localparam logic [TOTAL_W:0] TOTAL_MAX = {1'b0, {TOTAL_W{1'b1}}};

    logic [TOTAL_W:0] incr;
    logic [TOTAL_W:0] sum;

    always_comb begin
        incr = '0;
        if (issue_5)
            incr = (TOTAL_W+1)'(COIN_LO_VAL);
        else if (issue_10)
            incr = (TOTAL_W+1)'(COIN_HI_VAL);
        sum = {1'b0, total_cents} + incr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            total_cents <= '0;
        else if (sum > TOTAL_MAX)
            total_cents <= TOTAL_MAX[TOTAL_W-1:0];
        else
            total_cents <= sum[TOTAL_W-1:0];
    end
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Bench for coin_input_conditioner with DB_CYCLES=4. Expected pulses
// (cycle, kind) are queued as stimulus is driven; a negedge monitor pops and
// compares them whenever the DUT pulses any output.
// kind encoding: bit0 = in_5, bit1 = in_10, bit2 = coin_drop.
module tb_coin_input_conditioner;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst;
    logic btn_5;
    logic btn_10;
    logic hold;
    logic in_5;
    logic in_10;
    logic coin_drop;
`ifdef COIN_TOTAL_EN
    logic [11:0] total_cents;
`endif

    coin_input_conditioner #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_5     (btn_5),
        .btn_10    (btn_10),
        .hold      (hold),
        .in_5      (in_5),
        .in_10     (in_10),
        .coin_drop (coin_drop)
`ifdef COIN_TOTAL_EN
        ,
        .total_cents (total_cents)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    int  mon_kind;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input int c, input int k);
        exp_q.push_back('{cyc: c, kind: k});
    endtask

    task automatic end_test(input string tag);
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (!rst && (in_5 || in_10 || coin_drop)) begin
            mon_kind = {29'd0, coin_drop, in_10, in_5};
            check("excl", int'(in_5 && in_10), 0);
            if (exp_q.size() == 0) begin
                check("unexpected", mon_kind, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("kind", mon_kind, mon_e.kind);
                check("cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1; btn_5 = 1'b0; btn_10 = 1'b0; hold = 1'b0;
        tick(3);
        check("rst_in_5", in_5, 0);
        check("rst_in_10", in_10, 0);
        check("rst_drop", coin_drop, 0);
        rst = 1'b0;
        tick(2);

        // 1: clean press, single pulse at edge DB+2, nothing on release
        t = cyc; btn_5 = 1'b1; expect_ev(t + 1 + DB + 2, 1);
        tick(20); btn_5 = 1'b0; tick(15);
        end_test("t1_missing");

        // 2: bounce then stable
        btn_10 = 1'b1; tick(1); btn_10 = 1'b0; tick(1);
        btn_10 = 1'b1; tick(1); btn_10 = 1'b0; tick(1);
        t = cyc; btn_10 = 1'b1; expect_ev(t + 1 + DB + 2, 2);
        tick(20); btn_10 = 1'b0; tick(15);
        end_test("t2_missing");

        // 3: simultaneous presses
        t = cyc; btn_5 = 1'b1; btn_10 = 1'b1;
        expect_ev(t + 7, 1); expect_ev(t + 8, 2);
        tick(20); btn_5 = 1'b0; btn_10 = 1'b0; tick(15);
        end_test("t3_missing");

        // 4: press under hold, issued one edge after hold falls
        hold = 1'b1; btn_5 = 1'b1; tick(10);
        hold = 1'b0; t = cyc; expect_ev(t + 1, 1);
        tick(10); btn_5 = 1'b0; tick(15);
        end_test("t4_missing");

        // 5: two presses under hold -> one drop, one coin
        hold = 1'b1;
        btn_5 = 1'b1; tick(8); btn_5 = 1'b0; tick(8);
        t = cyc; btn_5 = 1'b1; expect_ev(t + 1 + DB + 1, 4);
        tick(8); btn_5 = 1'b0; tick(8);
        hold = 1'b0; t = cyc; expect_ev(t + 1, 1);
        tick(15);
        end_test("t5_missing");

        // 6a: reset mid-debounce, held switch re-debounced from scratch
        btn_5 = 1'b1; tick(4);
        rst = 1'b1; #1;
        check("rst_mid_in_5", in_5, 0);
        check("rst_mid_drop", coin_drop, 0);
        tick(2);
        rst = 1'b0; t = cyc; expect_ev(t + 7, 1);
        tick(15); btn_5 = 1'b0; tick(15);
        end_test("t6a_missing");

        // 6b: async reset clears a live pulse immediately
        btn_10 = 1'b1; tick(7);
        check("pulse_pre_rst", in_10, 1);
        rst = 1'b1; #1;
        check("pulse_post_rst", in_10, 0);
        btn_10 = 1'b0; tick(3);
        rst = 1'b0; tick(15);
        end_test("t6b_missing");

`ifdef COIN_TOTAL_EN
        check("total_rst", int'(total_cents), 0);
        for (int i = 0; i < 411; i++) begin
            t = cyc; btn_10 = 1'b1; expect_ev(t + 7, 2);
            tick(7); btn_10 = 1'b0; tick(7);
            if (i == 408) check("total_4090", int'(total_cents), 4090);
            if (i == 409) check("total_sat", int'(total_cents), 4095);
        end
        check("total_stay", int'(total_cents), 4095);
        end_test("total_missing");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
